// File: rtl/cpu_multicycle.sv
// cpu_multicycle: multi-cycle RV32I core (no FENCE/ECALL/EBREAK/CSR).
// One instruction walks FETCH -> DECODE -> EXEC -> [MEM ->] WB over a single
// shared instruction/data port with a req/ready handshake.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   mem_req/we/addr       request valid, store flag, word-aligned byte address
//   mem_wdata/wstrb       store data replicated across lanes, lane strobes
//   mem_ready/rdata       completion strobe and read data (same cycle)
//   retire                one-cycle pulse per committed instruction
//   halted                core stopped on an error
//   pc_dbg                PC of the instruction in flight
module cpu_multicycle #(
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter bit          HALT_ON_ERR = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        retire,
  output logic        halted,
  output logic [31:0] pc_dbg
);

  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_JAL   = 7'h6F;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_LD    = 7'h03;
  localparam logic [6:0] OP_ST    = 7'h23;
  localparam logic [6:0] OP_IMM   = 7'h13;
  localparam logic [6:0] OP_REG   = 7'h33;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [31:0] res_q, res_d, npc_q, npc_d, ea_q, ea_d;
  logic        nop_q, nop_d, req_q, req_d;
  logic [31:0] rf_q [32];
  logic        rf_we;
  logic [31:0] rf_wd;

  logic [6:0] opc, f7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  assign opc = ir_q[6:0];
  assign rd  = ir_q[11:7];
  assign f3  = ir_q[14:12];
  assign rs1 = ir_q[19:15];
  assign rs2 = ir_q[24:20];
  assign f7  = ir_q[31:25];

  logic is_ld, is_st;
  assign is_ld = (opc == OP_LD);
  assign is_st = (opc == OP_ST);

  // Immediate generation
  logic [31:0] imm_dec;
  always_comb begin
    case (opc)
      OP_LUI, OP_AUIPC: imm_dec = {ir_q[31:12], 12'b0};
      OP_JAL:  imm_dec = {{12{ir_q[31]}}, ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      OP_BR:   imm_dec = {{20{ir_q[31]}}, ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      OP_ST:   imm_dec = {{21{ir_q[31]}}, ir_q[30:25], ir_q[11:7]};
      default: imm_dec = {{21{ir_q[31]}}, ir_q[30:20]};
    endcase
  end

  // Execute: ALU, branch compare, targets, error detection
  logic        is_op, alt, cond, taken, legal, mis, err;
  logic [31:0] opb, alu, sra, sum, tgt, res;
  always_comb begin
    is_op = (opc == OP_REG);
    opb   = is_op ? b_q : imm_q;
    // bit 30 selects SUB/SRA; for OP-IMM only the shift-right form honours it
    alt   = ir_q[30] & (is_op | (f3 == 3'd5));
    sra   = $signed(a_q) >>> opb[4:0];
    case (f3)
      3'd0:    alu = alt ? a_q - opb : a_q + opb;
      3'd1:    alu = a_q << opb[4:0];
      3'd2:    alu = {31'b0, $signed(a_q) < $signed(opb)};
      3'd3:    alu = {31'b0, a_q < opb};
      3'd4:    alu = a_q ^ opb;
      3'd5:    alu = alt ? sra : a_q >> opb[4:0];
      3'd6:    alu = a_q | opb;
      default: alu = a_q & opb;
    endcase
    case (f3)
      3'd0:    cond = (a_q == b_q);
      3'd1:    cond = (a_q != b_q);
      3'd4:    cond = $signed(a_q) < $signed(b_q);
      3'd5:    cond = $signed(a_q) >= $signed(b_q);
      3'd6:    cond = a_q < b_q;
      3'd7:    cond = a_q >= b_q;
      default: cond = 1'b0;
    endcase
    sum   = a_q + imm_q;
    taken = (opc == OP_JAL) | (opc == OP_JALR) | ((opc == OP_BR) & cond);
    tgt   = (opc == OP_JALR) ? {sum[31:1], 1'b0} : pc_q + imm_q;
    case (opc)
      OP_LUI, OP_AUIPC, OP_JAL: legal = 1'b1;
      OP_JALR: legal = (f3 == 3'd0);
      OP_BR:   legal = (f3 != 3'd2) && (f3 != 3'd3);
      OP_LD:   legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
      OP_ST:   legal = (f3 <= 3'd2);
      OP_IMM:  legal = (f3 == 3'd1) ? (f7 == 7'h00) :
                       (f3 == 3'd5) ? ((f7 == 7'h00) || (f7 == 7'h20)) : 1'b1;
      OP_REG:  legal = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
      default: legal = 1'b0;
    endcase
    mis = (is_ld | is_st) &
          (((f3[1:0] == 2'd1) & sum[0]) | ((f3[1:0] == 2'd2) & (sum[1:0] != 2'b00)));
    err = ~legal | mis | (taken & (tgt[1:0] != 2'b00));
    case (opc)
      OP_LUI:           res = imm_q;
      OP_AUIPC:         res = pc_q + imm_q;
      OP_JAL, OP_JALR:  res = pc_q + 32'd4;
      default:          res = alu;
    endcase
  end

  // Store lane placement
  logic [31:0] st_data;
  logic [3:0]  st_strb;
  always_comb begin
    case (f3[1:0])
      2'd0:    begin st_data = {4{b_q[7:0]}};  st_strb = 4'b0001 << ea_q[1:0]; end
      2'd1:    begin st_data = {2{b_q[15:0]}}; st_strb = ea_q[1] ? 4'b1100 : 4'b0011; end
      default: begin st_data = b_q;            st_strb = 4'b1111; end
    endcase
  end

  // Load lane extraction; word loads are aligned so the shift is zero
  logic [31:0] ld_sh, ld_val;
  always_comb begin
    ld_sh = mem_rdata >> {ea_q[1:0], 3'b000};
    case (f3)
      3'd0:    ld_val = {{24{ld_sh[7]}}, ld_sh[7:0]};
      3'd1:    ld_val = {{16{ld_sh[15]}}, ld_sh[15:0]};
      3'd4:    ld_val = {24'b0, ld_sh[7:0]};
      3'd5:    ld_val = {16'b0, ld_sh[15:0]};
      default: ld_val = ld_sh;
    endcase
  end

  // FSM next state / datapath
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    imm_d   = imm_q;
    res_d   = res_q;
    npc_d   = npc_q;
    ea_d    = ea_q;
    nop_d   = nop_q;
    rf_we   = 1'b0;
    rf_wd   = res_q;
    case (state_q)
      S_FETCH: if (req_q && mem_ready) begin
        ir_d    = mem_rdata;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d     = rf_q[rs1];
        b_d     = rf_q[rs2];
        imm_d   = imm_dec;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d = res;
        ea_d  = sum;
        nop_d = err;
        npc_d = (taken && !err) ? tgt : pc_q + 32'd4;
        if (err && HALT_ON_ERR)      state_d = S_HALT;
        else if (!err && (is_ld || is_st)) state_d = S_MEM;
        else                         state_d = S_WB;
      end
      S_MEM: if (req_q && mem_ready) begin
        if (is_ld) res_d = ld_val;
        state_d = S_WB;
      end
      S_WB: begin
        pc_d    = npc_q;
        rf_we   = !nop_q && (opc != OP_BR) && !is_st && (rd != 5'd0);
        state_d = S_FETCH;
      end
      default: state_d = S_HALT;
    endcase
    // Registered request: rises on entry to FETCH/MEM, drops the cycle after
    // completion, and stays low for the first cycle out of reset.
    req_d = (state_d == S_FETCH) || (state_d == S_MEM);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      res_q   <= '0;
      npc_q   <= '0;
      ea_q    <= '0;
      nop_q   <= 1'b0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      res_q   <= res_d;
      npc_q   <= npc_d;
      ea_q    <= ea_d;
      nop_q   <= nop_d;
      if (rf_we) rf_q[rd] <= rf_wd;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = (state_q == S_MEM) && is_st;
  assign mem_addr  = (state_q == S_MEM) ? {ea_q[31:2], 2'b00} : pc_q;
  assign mem_wdata = st_data;
  assign mem_wstrb = mem_we ? st_strb : 4'b0000;
  assign retire    = (state_q == S_WB);
  assign halted    = (state_q == S_HALT);
  assign pc_dbg    = pc_q;

endmodule

// File: tb/tb_cpu_multicycle.sv
module tb_cpu_multicycle;
  logic        clk, rst_n;
  logic        mem_req, mem_we, mem_ready, retire, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_dbg;
  logic [3:0]  mem_wstrb;

  cpu_multicycle #(.RESET_PC(32'h100), .HALT_ON_ERR(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .retire(retire),
    .halted(halted), .pc_dbg(pc_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } st_t;
  st_t         sb_q[$];
  int          rt_q[$];
  logic [31:0] fa_q[$];
  logic [31:0] mem [0:1023];
  int          n_chk = 0, n_err = 0;
  int          ws = 0, cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  task automatic put(input logic [31:0] a, input logic [31:0] w);
    mem[a[11:2]] = w;
  endtask
  task automatic exp_st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    st_t e;
    e.addr = a; e.data = d; e.strb = s;
    sb_q.push_back(e);
  endtask

  // Memory responder with ws wait states; also monitors retire, fetches, stores
  logic [31:0] h_addr, h_wdata;
  logic [3:0]  h_strb;
  logic        h_we, h_vld;
  int          wcnt;
  initial begin
    mem_ready = 1'b0; mem_rdata = '0; wcnt = 0; h_vld = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (retire) rt_q.push_back(cyc);
      if (!rst_n || !mem_req) begin
        mem_ready = 1'b0; wcnt = 0; h_vld = 1'b0;
      end else begin
        if (h_vld) begin
          chk("hold_addr", mem_addr, h_addr);
          chk("hold_we", {31'b0, mem_we}, {31'b0, h_we});
          chk("hold_wdata", mem_wdata, h_wdata);
          chk("hold_wstrb", {28'b0, mem_wstrb}, {28'b0, h_strb});
        end
        if (wcnt >= ws) begin
          mem_ready = 1'b1; wcnt = 0; h_vld = 1'b0;
          if (mem_we) begin
            chk("st_pending", {31'b0, sb_q.size() != 0}, 32'd1);
            if (sb_q.size() != 0) begin
              st_t e;
              e = sb_q.pop_front();
              chk("st_addr", mem_addr, e.addr);
              chk("st_data", mem_wdata, e.data);
              chk("st_strb", {28'b0, mem_wstrb}, {28'b0, e.strb});
            end
            for (int b = 0; b < 4; b++)
              if (mem_wstrb[b]) mem[mem_addr[11:2]][8*b +: 8] = mem_wdata[8*b +: 8];
          end else begin
            mem_rdata = mem[mem_addr[11:2]];
            if (mem_addr == pc_dbg) fa_q.push_back(mem_addr);
          end
        end else begin
          mem_ready = 1'b0; wcnt++; h_vld = 1'b1;
          h_addr = mem_addr; h_we = mem_we; h_wdata = mem_wdata; h_strb = mem_wstrb;
        end
      end
    end
  end

  task automatic wait_rt(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && rt_q.size() < n; i++) @(negedge clk);
    #1;
    chk(tag, {31'b0, rt_q.size() >= n}, 32'd1);
  endtask

  function automatic logic [31:0] dt(int i);
    if (i < 1 || i >= rt_q.size()) return 32'hFFFF_FFFF;
    return 32'(rt_q[i] - rt_q[i-1]);
  endfunction

  function automatic logic [31:0] fa(int i);
    if (i >= fa_q.size()) return 32'hFFFF_FFFF;
    return fa_q[i];
  endfunction

  initial begin
    bit found;
    rst_n = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    // Program A: shifts, byte/half/word memory ops, compares, JALR, x0
    put(32'h100, enc_i(12'hFFF, 0, 0, 1, 7'h13));        // addi x1,x0,-1
    put(32'h104, enc_i(12'h404, 1, 5, 2, 7'h13));        // srai x2,x1,4
    put(32'h108, enc_i(12'h004, 1, 5, 3, 7'h13));        // srli x3,x1,4
    put(32'h10C, enc_i(12'h200, 0, 0, 5, 7'h13));        // addi x5,x0,0x200
    put(32'h110, enc_s(12'd0, 2, 5, 2));                 // sw x2,0(x5)
    put(32'h114, enc_s(12'd4, 3, 5, 2));                 // sw x3,4(x5)
    put(32'h118, enc_i(12'h0A5, 0, 0, 6, 7'h13));        // addi x6,x0,0xA5
    put(32'h11C, enc_s(12'd3, 6, 5, 0));                 // sb x6,3(x5)
    put(32'h120, enc_i(12'd3, 5, 0, 4, 7'h03));          // lb x4,3(x5)
    put(32'h124, enc_s(12'd8, 4, 5, 2));                 // sw x4,8(x5)
    put(32'h128, enc_i(12'd4, 5, 5, 7, 7'h03));          // lhu x7,4(x5)
    put(32'h12C, enc_s(12'd10, 6, 5, 1));                // sh x6,10(x5)
    put(32'h130, enc_i(12'd8, 5, 1, 8, 7'h03));          // lh x8,8(x5)
    put(32'h134, enc_s(12'd12, 7, 5, 2));                // sw x7,12(x5)
    put(32'h138, enc_s(12'd16, 8, 5, 2));                // sw x8,16(x5)
    put(32'h13C, enc_r(7'h00, 0, 1, 2, 9));              // slt x9,x1,x0
    put(32'h140, enc_r(7'h00, 0, 1, 3, 10));             // sltu x10,x1,x0
    put(32'h144, enc_r(7'h20, 1, 9, 0, 11));             // sub x11,x9,x1
    put(32'h148, enc_s(12'd20, 9, 5, 2));
    put(32'h14C, enc_s(12'd24, 10, 5, 2));
    put(32'h150, enc_s(12'd28, 11, 5, 2));
    put(32'h154, enc_i(12'h301, 0, 0, 13, 7'h13));       // addi x13,x0,0x301
    put(32'h158, enc_i(12'd0, 13, 0, 14, 7'h67));        // jalr x14,0(x13)
    put(32'h300, enc_i(12'd5, 0, 0, 0, 7'h13));          // addi x0,x0,5
    put(32'h304, enc_s(12'd32, 14, 5, 2));
    put(32'h308, enc_s(12'd36, 0, 5, 2));
    put(32'h30C, 32'h0000_006F);                         // jal x0,0
    exp_st(32'h200, 32'hFFFF_FFFF, 4'hF);
    exp_st(32'h204, 32'h0FFF_FFFF, 4'hF);
    exp_st(32'h200, 32'hA5A5_A5A5, 4'b1000);
    exp_st(32'h208, 32'hFFFF_FFA5, 4'hF);
    exp_st(32'h208, 32'h00A5_00A5, 4'b1100);
    exp_st(32'h20C, 32'h0000_FFFF, 4'hF);
    exp_st(32'h210, 32'hFFFF_FFA5, 4'hF);
    exp_st(32'h214, 32'h1, 4'hF);
    exp_st(32'h218, 32'h0, 4'hF);
    exp_st(32'h21C, 32'h2, 4'hF);
    exp_st(32'h220, 32'h15C, 4'hF);
    exp_st(32'h224, 32'h0, 4'hF);

    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_retire", {31'b0, retire}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_pc", pc_dbg, 32'h100);
    rst_n = 1'b1;
    for (int i = 0; i < 20 && fa_q.size() == 0; i++) @(negedge clk);
    #1;
    chk("fetch0", fa(0), 32'h100);
    chk("no_early_retire", 32'(rt_q.size()), 32'd0);

    wait_rt("retiresA", 27, 400);
    chk("lat_srai", dt(1), 32'd4);
    chk("lat_srli", dt(2), 32'd4);
    chk("lat_sw", dt(4), 32'd5);
    chk("lat_lb", dt(8), 32'd5);
    chk("lat_jalr", dt(22), 32'd4);
    chk("jalr_tgt", fa(23), 32'h300);
    chk("sb_leftA", 32'(sb_q.size()), 32'd0);

    // Program B with 3 wait states: backward BEQ, then misaligned LW halts
    put(32'h100, enc_i(12'd0, 0, 0, 2, 7'h13));          // addi x2,x0,0
    put(32'h104, enc_i(12'd1, 2, 0, 2, 7'h13));          // addi x2,x2,1
    put(32'h108, enc_i(12'hFFF, 2, 0, 3, 7'h13));        // addi x3,x2,-1
    put(32'h10C, enc_b(13'h1FF8, 0, 3, 0));              // beq x3,x0,-8
    put(32'h110, enc_i(12'h200, 0, 0, 5, 7'h13));        // addi x5,x0,0x200
    put(32'h114, enc_s(12'h010, 2, 5, 2));               // sw x2,16(x5)
    put(32'h118, enc_i(12'd2, 5, 2, 7, 7'h03));          // lw x7,2(x5) -> error
    put(32'h11C, enc_s(12'd0, 7, 5, 2));                 // sw x7,0(x5) never runs
    exp_st(32'h210, 32'h2, 4'hF);
    ws = 3;

    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      #1;
      if (mem_req && !mem_we && !mem_ready) found = 1'b1;
    end
    chk("mid_fetch", {31'b0, found}, 32'd1);
    rt_q.delete();
    fa_q.delete();
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("rst2_req", {31'b0, mem_req}, 32'd0);
    chk("rst2_pc", pc_dbg, 32'h100);
    rst_n = 1'b1;

    wait_rt("retiresB", 9, 400);
    for (int i = 0; i < 100 && !halted; i++) @(negedge clk);
    #1;
    chk("halted", {31'b0, halted}, 32'd1);
    repeat (10) @(negedge clk);
    #1;
    chk("halt_retires", 32'(rt_q.size()), 32'd9);
    chk("halt_pc", pc_dbg, 32'h118);
    chk("halt_req", {31'b0, mem_req}, 32'd0);
    chk("refetch", fa(0), 32'h100);
    chk("beq_tgt", fa(4), 32'h104);
    chk("lat_beq_t", dt(3), 32'd7);
    chk("lat_beq_nt", dt(6), 32'd7);
    chk("lat_sw_ws", dt(8), 32'd11);
    chk("sb_leftB", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
